// File: rtl/hazard_fwd_unit_param.sv
// hazard_fwd_unit_param
// Forwarding and hazard unit that sits beside the ID stage of the 5-stage pipeline.
// For each ID read port it picks a bypass source from EX, MEM, WB or the register file.
// It detects load-use hazards and tracks an in-flight multiply so MFHI/MFLO can wait for HI/LO.
// It also counts stalled cycles, saturating at all-ones, for performance debug.
module hazard_fwd_unit_param #(
    parameter int NUM_RD   = 2,
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_RD*REG_AW-1:0] id_src,
    input  logic [NUM_RD-1:0]        id_src_used,
    input  logic                     id_reads_hilo,
    input  logic [REG_AW-1:0]        ex_dst,
    input  logic                     ex_wr,
    input  logic                     ex_is_load,
    input  logic [REG_AW-1:0]        mem_dst,
    input  logic                     mem_wr,
    input  logic [REG_AW-1:0]        wb_dst,
    input  logic                     wb_wr,
    input  logic                     mult_start,
    input  logic                     flush,
    output logic [NUM_RD*2-1:0]      fwd_sel,
    output logic                     stall,
    output logic                     mult_busy,
    output logic                     mult_done,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int MC_W = $clog2(MULT_LAT + 1);
    localparam logic [MC_W-1:0] MULT_LOAD = MC_W'(MULT_LAT);
    localparam logic [MC_W-1:0] MC_ONE    = MC_W'(1);

    logic [MC_W-1:0] mult_cnt;
    logic [MC_W-1:0] mult_cnt_nxt;
    logic            mult_done_nxt;
    logic            load_use;
    logic            hilo_stall;

    // Per-port bypass select with EX > MEM > WB > RF priority; a load in EX cannot forward yet, so it stalls instead
    always_comb begin
        fwd_sel  = '0;
        load_use = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (id_src_used[k] && (id_src[k*REG_AW +: REG_AW] != '0)) begin
                if (ex_wr && (ex_dst == id_src[k*REG_AW +: REG_AW])) begin
                    if (ex_is_load) begin
                        load_use = 1'b1;
                    end else begin
                        fwd_sel[k*2 +: 2] = 2'b11;
                    end
                end else if (mem_wr && (mem_dst == id_src[k*REG_AW +: REG_AW])) begin
                    fwd_sel[k*2 +: 2] = 2'b10;
                end else if (wb_wr && (wb_dst == id_src[k*REG_AW +: REG_AW])) begin
                    fwd_sel[k*2 +: 2] = 2'b01;
                end
            end
        end
    end

    // HI/LO scoreboard next state: flush beats a new multiply, a new multiply restarts the countdown
    always_comb begin
        mult_cnt_nxt  = mult_cnt;
        mult_done_nxt = 1'b0;
        if (flush) begin
            mult_cnt_nxt = '0;
        end else if (mult_start) begin
            mult_cnt_nxt = MULT_LOAD;
        end else if (mult_cnt != '0) begin
            mult_cnt_nxt  = mult_cnt - MC_ONE;
            mult_done_nxt = (mult_cnt == MC_ONE);
        end
    end

    assign mult_busy  = (mult_cnt != '0);
    assign hilo_stall = id_reads_hilo & (mult_busy | mult_start);
    assign stall      = load_use | hilo_stall;

    // Multiply countdown register and its registered completion pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mult_cnt  <= '0;
            mult_done <= 1'b0;
        end else begin
            mult_cnt  <= mult_cnt_nxt;
            mult_done <= mult_done_nxt;
        end
    end

    // Saturating count of cycles in which the pipeline was held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit_param.sv
// tb_hazard_fwd_unit_param
// Scoreboard bench: a driver issues directed and random cycles and pushes the predicted outputs,
// a monitor pops them on the falling edge and compares. The model tracks the multiplier by cycle numbers.
module tb_hazard_fwd_unit_param;

    localparam int NUM_RD   = 2;
    localparam int REG_AW   = 5;
    localparam int MULT_LAT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [NUM_RD-1:0][REG_AW-1:0] src;
        logic [NUM_RD-1:0]             used;
        logic                          hilo;
        logic [REG_AW-1:0]             ex_dst;
        logic [REG_AW-1:0]             mem_dst;
        logic [REG_AW-1:0]             wb_dst;
        logic                          ex_wr;
        logic                          ex_is_load;
        logic                          mem_wr;
        logic                          wb_wr;
        logic                          start;
        logic                          flush;
    } stim_t;

    typedef struct {
        logic [NUM_RD*2-1:0] fwd;
        logic                stall;
        logic                busy;
        logic                done;
        logic [CNT_W-1:0]    cnt;
        int                  cyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_RD*REG_AW-1:0] id_src = '0;
    logic [NUM_RD-1:0]        id_src_used = '0;
    logic                     id_reads_hilo = 1'b0;
    logic [REG_AW-1:0]        ex_dst = '0;
    logic                     ex_wr = 1'b0;
    logic                     ex_is_load = 1'b0;
    logic [REG_AW-1:0]        mem_dst = '0;
    logic                     mem_wr = 1'b0;
    logic [REG_AW-1:0]        wb_dst = '0;
    logic                     wb_wr = 1'b0;
    logic                     mult_start = 1'b0;
    logic                     flush = 1'b0;
    logic [NUM_RD*2-1:0]      fwd_sel;
    logic                     stall;
    logic                     mult_busy;
    logic                     mult_done;
    logic [CNT_W-1:0]         stall_cnt;

    hazard_fwd_unit_param #(
        .NUM_RD(NUM_RD), .REG_AW(REG_AW), .MULT_LAT(MULT_LAT), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .id_src(id_src), .id_src_used(id_src_used), .id_reads_hilo(id_reads_hilo),
        .ex_dst(ex_dst), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
        .mem_dst(mem_dst), .mem_wr(mem_wr), .wb_dst(wb_dst), .wb_wr(wb_wr),
        .mult_start(mult_start), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall), .mult_busy(mult_busy),
        .mult_done(mult_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state: cycle number, last busy cycle, cycle of the expected done pulse
    int    cyc = 0;
    int    last_busy = -1;
    int    done_cycle = -1;
    int    m_cnt = 0;
    stim_t cur_in;
    logic  cur_stall = 1'b0;

    function automatic stim_t zeroStim();
        stim_t s;
        s.src = '0; s.used = '0; s.hilo = 1'b0;
        s.ex_dst = '0; s.mem_dst = '0; s.wb_dst = '0;
        s.ex_wr = 1'b0; s.ex_is_load = 1'b0; s.mem_wr = 1'b0; s.wb_wr = 1'b0;
        s.start = 1'b0; s.flush = 1'b0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        for (int k = 0; k < NUM_RD; k++) s.src[k] = REG_AW'($urandom_range(0, 3));
        s.used       = NUM_RD'($urandom);
        s.hilo       = ($urandom_range(0, 2) == 0);
        s.ex_dst     = REG_AW'($urandom_range(0, 3));
        s.mem_dst    = REG_AW'($urandom_range(0, 3));
        s.wb_dst     = REG_AW'($urandom_range(0, 3));
        s.ex_wr      = 1'($urandom);
        s.ex_is_load = ($urandom_range(0, 3) == 0);
        s.mem_wr     = 1'($urandom);
        s.wb_wr      = 1'($urandom);
        s.start      = ($urandom_range(0, 7) == 0);
        s.flush      = ($urandom_range(0, 15) == 0);
        return s;
    endfunction

    // Expected outputs for the current cycle from the rules: scan stages in priority order per port
    function automatic exp_t predict(stim_t s);
        exp_t e;
        logic lu = 1'b0;
        logic [REG_AW-1:0] dsts [3];
        logic wrs [3];
        dsts[0] = s.ex_dst;  wrs[0] = s.ex_wr;
        dsts[1] = s.mem_dst; wrs[1] = s.mem_wr;
        dsts[2] = s.wb_dst;  wrs[2] = s.wb_wr;
        e.fwd = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            int hit = -1;
            if (s.used[k] && s.src[k] != 0) begin
                for (int j = 0; j < 3; j++)
                    if (hit < 0 && wrs[j] && dsts[j] == s.src[k]) hit = j;
            end
            if (hit == 0 && s.ex_is_load) lu = 1'b1;
            else if (hit >= 0) e.fwd[k*2 +: 2] = 2'(3 - hit);
        end
        e.busy  = (cyc <= last_busy);
        e.done  = (cyc == done_cycle);
        e.stall = lu | (s.hilo & (e.busy | s.start));
        e.cnt   = CNT_W'(m_cnt);
        e.cyc   = cyc;
        return e;
    endfunction

    // Advance the model across one rising edge using the previous cycle's inputs
    task automatic modelEdge();
        if (cur_stall && m_cnt < CNT_MAX) m_cnt++;
        if (cur_in.flush) begin
            if (last_busy > cyc) last_busy = cyc;
            done_cycle = -1;
        end else if (cur_in.start) begin
            last_busy  = cyc + MULT_LAT;
            done_cycle = cyc + MULT_LAT + 1;
        end
        cyc++;
    endtask

    // Drive one cycle of inputs, optionally with an async reset pulse, and queue the prediction
    task automatic applyStimulus(input stim_t s, input bit do_rst);
        exp_t e;
        @(posedge clk); #1;
        modelEdge();
        if (do_rst) begin
            rst_n = 1'b0;
            m_cnt = 0; last_busy = -1; done_cycle = -1;
        end
        id_src = s.src; id_src_used = s.used; id_reads_hilo = s.hilo;
        ex_dst = s.ex_dst; ex_wr = s.ex_wr; ex_is_load = s.ex_is_load;
        mem_dst = s.mem_dst; mem_wr = s.mem_wr; wb_dst = s.wb_dst; wb_wr = s.wb_wr;
        mult_start = s.start; flush = s.flush;
        cur_in = s;
        e = predict(s);
        cur_stall = e.stall;
        sb.push_back(e);
        if (do_rst) begin
            @(negedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic checkField(input string name, input int c, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("fwd_sel", e.cyc, int'(fwd_sel), int'(e.fwd));
        checkField("stall", e.cyc, int'(stall), int'(e.stall));
        checkField("mult_busy", e.cyc, int'(mult_busy), int'(e.busy));
        checkField("mult_done", e.cyc, int'(mult_done), int'(e.done));
        checkField("stall_cnt", e.cyc, int'(stall_cnt), int'(e.cnt));
    endtask

    // Monitor: compare whatever the driver predicted for this cycle
    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        stim_t s;
        cur_in = zeroStim();
        applyStimulus(zeroStim(), 1'b1);

        // EX has priority over MEM for port 0; port 1 prefers MEM over WB
        s = zeroStim();
        s.src[0] = 5'd8; s.used = 2'b11; s.src[1] = 5'd9;
        s.ex_dst = 5'd8; s.ex_wr = 1'b1; s.mem_dst = 5'd8; s.mem_wr = 1'b1;
        applyStimulus(s, 1'b0);
        s.ex_wr = 1'b0; s.mem_dst = 5'd9; s.wb_dst = 5'd9; s.wb_wr = 1'b1;
        applyStimulus(s, 1'b0);
        s = zeroStim(); s.used = 2'b11; s.ex_wr = 1'b1; s.mem_wr = 1'b1; s.wb_wr = 1'b1;
        applyStimulus(s, 1'b0);

        // Load-use: one stall, then forward from MEM
        applyStimulus(zeroStim(), 1'b1);
        s = zeroStim(); s.src[0] = 5'd8; s.used = 2'b01;
        s.ex_dst = 5'd8; s.ex_wr = 1'b1; s.ex_is_load = 1'b1;
        applyStimulus(s, 1'b0);
        s.ex_wr = 1'b0; s.ex_is_load = 1'b0; s.mem_dst = 5'd8; s.mem_wr = 1'b1;
        applyStimulus(s, 1'b0);

        // Multiply with MFLO held in ID
        applyStimulus(zeroStim(), 1'b1);
        s = zeroStim(); s.hilo = 1'b1; s.start = 1'b1;
        applyStimulus(s, 1'b0);
        s.start = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(s, 1'b0);

        // Restarted multiply: only the newest one completes
        s = zeroStim(); s.start = 1'b1;
        applyStimulus(s, 1'b0);
        s.start = 1'b0;
        applyStimulus(s, 1'b0);
        s.start = 1'b1;
        applyStimulus(s, 1'b0);
        s.start = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(s, 1'b0);

        // Reset in the middle of a multiply
        s = zeroStim(); s.start = 1'b1; s.hilo = 1'b1;
        applyStimulus(s, 1'b0);
        s.start = 1'b0;
        applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(s, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) applyStimulus(randStim(), ($urandom_range(0, 199) == 0));

        applyStimulus(zeroStim(), 1'b0);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
